// File: rtl/uart_loader.sv
// UART-driven bus loader: decodes write/read frames from a byte stream and runs
// the matching bus cycles, returning one reply byte for reads.
module uart_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        bus_access_strobe,
   input  logic [7:0]  bus_d_in,
   output logic [15:0] a,
   output logic [7:0]  d_out,
   output logic        select,
   output logic        r_w_n,
   output logic        busy,
   output logic        frame_error
);

   localparam int unsigned TmoW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CmdWrite = 8'h57;
   localparam logic [7:0] CmdRead  = 8'h52;

   typedef enum logic [2:0] {
      StIdle, StAddrHi, StAddrLo, StLen, StData, StWrite, StRead, StReply
   } state_e;

   state_e          state_q, state_d;
   logic            cmd_read_q, cmd_read_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     a_q, a_d;
   logic [7:0]      d_out_q, d_out_d;
   logic [8:0]      count_q, count_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic            ferr_q, ferr_d;
   logic            in_frame;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cmd_read_q <= 1'b0;
         addr_q     <= '0;
         a_q        <= '0;
         d_out_q    <= '0;
         count_q    <= '0;
         tmo_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_read_q <= cmd_read_d;
         addr_q     <= addr_d;
         a_q        <= a_d;
         d_out_q    <= d_out_d;
         count_q    <= count_d;
         tmo_q      <= tmo_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_read_d = cmd_read_q;
      addr_d     = addr_q;
      a_d        = a_q;
      d_out_d    = d_out_q;
      count_d    = count_q;
      tmo_d      = '0;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      ferr_d     = ferr_q;

      in_frame = (state_q == StAddrHi) || (state_q == StAddrLo) ||
                 (state_q == StLen) || (state_q == StData);
      if (in_frame) begin
         tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (rx_valid && (rx_data == CmdWrite || rx_data == CmdRead)) begin
               state_d    = StAddrHi;
               cmd_read_d = (rx_data == CmdRead);
               ferr_d     = 1'b0;
            end
         end
         StAddrHi: begin
            if (rx_valid) begin
               addr_d[15:8] = rx_data;
               state_d      = StAddrLo;
            end
         end
         StAddrLo: begin
            if (rx_valid) begin
               addr_d[7:0] = rx_data;
               state_d     = cmd_read_q ? StRead : StLen;
            end
         end
         StLen: begin
            if (rx_valid) begin
               count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
               state_d = StData;
            end
         end
         StData: begin
            if (rx_valid) begin
               d_out_d = rx_data;
               state_d = StWrite;
            end
         end
         // Overrun takes priority over a completing bus cycle: the cycle is abandoned.
         StWrite: begin
            if (rx_valid) begin
               ferr_d  = 1'b1;
               state_d = StIdle;
            end else if (bus_access_strobe) begin
               addr_d  = addr_q + 16'd1;
               count_d = count_q - 1'b1;
               state_d = (count_q == 9'd1) ? StIdle : StData;
            end
         end
         StRead: begin
            if (rx_valid) begin
               ferr_d  = 1'b1;
               state_d = StIdle;
            end else if (bus_access_strobe) begin
               tx_data_d = bus_d_in;
               state_d   = StReply;
            end
         end
         StReply: begin
            if (rx_valid) begin
               ferr_d  = 1'b1;
               state_d = StIdle;
            end else if (!tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (in_frame && !rx_valid && tmo_q == TmoLast) begin
         ferr_d  = 1'b1;
         state_d = StIdle;
         tmo_d   = '0;
      end

      // The visible address only moves when a bus cycle is (re)entered.
      if (state_d == StWrite || state_d == StRead) begin
         a_d = addr_d;
      end
   end

   assign select      = (state_q == StWrite) || (state_q == StRead);
   assign r_w_n       = (state_q != StWrite);
   assign busy        = (state_q != StIdle);
   assign a           = a_q;
   assign d_out       = d_out_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: table-driven frames plus hand-written
// corner sequences, with a scoreboard for bus transfers and reply bytes.
module tb_uart_loader;

   localparam int unsigned TMO = 64;

   logic        clk;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        bus_access_strobe;
   logic [7:0]  bus_d_in;
   logic [15:0] a;
   logic [7:0]  d_out;
   logic        select;
   logic        r_w_n;
   logic        busy;
   logic        frame_error;

   uart_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .tx_busy           (tx_busy),
      .tx_data           (tx_data),
      .tx_start          (tx_start),
      .bus_access_strobe (bus_access_strobe),
      .bus_d_in          (bus_d_in),
      .a                 (a),
      .d_out             (d_out),
      .select            (select),
      .r_w_n             (r_w_n),
      .busy              (busy),
      .frame_error       (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
   } bus_t;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [7:0]  len;
      logic [7:0]  seed;
      logic [7:0]  step;
      logic [7:0]  rdata;
   } vec_t;

   bus_t       exp_bus[$];
   logic [7:0] exp_tx[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         sel_total = 0;
   int         tx_total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor samples mid-cycle, after the stimulus for the coming edge is settled.
   always begin
      bus_t e;
      @(negedge clk);
      #1;
      if (reset_n) begin
         if (select) sel_total++;
         if (select && bus_access_strobe) begin
            if (exp_bus.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL bus_extra_xfer: got a=%h r_w_n=%b, required no transfer", a, r_w_n);
            end else begin
               e = exp_bus.pop_front();
               check("bus_r_w_n", {31'd0, r_w_n}, {31'd0, e.rw});
               check("bus_a", {16'd0, a}, {16'd0, e.addr});
               if (!e.rw) check("bus_d_out", {24'd0, d_out}, {24'd0, e.data});
            end
         end
         if (tx_start) begin
            tx_total++;
            if (exp_tx.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_extra_start: got tx_data=%h, required no tx_start", tx_data);
            end else begin
               check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("idle_bound", {31'd0, busy}, 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      vec_t       t;
      int         n;
      int         sel0;
      int         tx0;
      logic [7:0] d;

      vecs[0] = '{rd:1'b0, addr:16'hD020, len:8'h01, seed:8'h0E, step:8'h00, rdata:8'h00};
      vecs[1] = '{rd:1'b0, addr:16'hFFFF, len:8'h02, seed:8'h11, step:8'h11, rdata:8'h00};
      vecs[2] = '{rd:1'b1, addr:16'hD021, len:8'h00, seed:8'h00, step:8'h00, rdata:8'h06};
      vecs[3] = '{rd:1'b0, addr:16'h1000, len:8'h00, seed:8'h00, step:8'h01, rdata:8'h00};
      vecs[4] = '{rd:1'b1, addr:16'h0000, len:8'h00, seed:8'h00, step:8'h00, rdata:8'hA5};
      vecs[5] = '{rd:1'b0, addr:16'h7FFE, len:8'h03, seed:8'hF0, step:8'h03, rdata:8'h00};

      reset_n           = 1'b0;
      rx_data           = 8'h00;
      rx_valid          = 1'b0;
      tx_busy           = 1'b0;
      bus_access_strobe = 1'b1;
      bus_d_in          = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_select", {31'd0, select}, 32'd0);
      check("rst_r_w_n", {31'd0, r_w_n}, 32'd1);
      check("rst_a", {16'd0, a}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_error", {31'd0, frame_error}, 32'd0);
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         t        = vecs[v];
         sel0     = sel_total;
         bus_d_in = t.rdata;
         n        = (t.len == 8'h00) ? 256 : int'(t.len);
         if (t.rd) begin
            exp_bus.push_back('{rw:1'b1, addr:t.addr, data:8'h00});
            exp_tx.push_back(t.rdata);
            send_byte(8'h52);
            send_byte(t.addr[15:8]);
            send_byte(t.addr[7:0]);
         end else begin
            send_byte(8'h57);
            send_byte(t.addr[15:8]);
            send_byte(t.addr[7:0]);
            send_byte(t.len);
            for (int i = 0; i < n; i++) begin
               d = t.seed + t.step * i[7:0];
               exp_bus.push_back('{rw:1'b0, addr:t.addr + 16'(i), data:d});
               send_byte(d);
            end
         end
         wait_idle(20);
         repeat (3) @(negedge clk);
         check("vec_sel_cycles", sel_total - sel0, t.rd ? 32'd1 : n);
         check("vec_busy", {31'd0, busy}, 32'd0);
         check("vec_frame_error", {31'd0, frame_error}, 32'd0);
      end

      // Read with delayed strobe and a busy transmitter.
      sel0              = sel_total;
      tx0               = tx_total;
      bus_access_strobe = 1'b0;
      tx_busy           = 1'b1;
      bus_d_in          = 8'h06;
      exp_bus.push_back('{rw:1'b1, addr:16'hD021, data:8'h00});
      exp_tx.push_back(8'h06);
      send_byte(8'h52);
      send_byte(8'hD0);
      @(negedge clk);
      rx_data  = 8'h21;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      bus_access_strobe = 1'b1;
      @(negedge clk);
      bus_access_strobe = 1'b0;
      repeat (3) @(negedge clk);
      check("rd_no_tx_while_busy", tx_total - tx0, 32'd0);
      check("rd_reply_busy", {31'd0, busy}, 32'd1);
      tx_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rd_tx_once", tx_total - tx0, 32'd1);
      check("rd_sel_cycles", sel_total - sel0, 32'd4);
      check("rd_idle", {31'd0, busy}, 32'd0);
      bus_access_strobe = 1'b1;

      // Inter-byte timeout: busy one cycle before the limit, error at the limit.
      send_byte(8'h57);
      @(negedge clk);
      rx_data  = 8'hD0;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (TMO - 1) @(negedge clk);
      check("tmo_before_busy", {31'd0, busy}, 32'd1);
      check("tmo_before_ferr", {31'd0, frame_error}, 32'd0);
      @(negedge clk);
      check("tmo_ferr", {31'd0, frame_error}, 32'd1);
      check("tmo_idle", {31'd0, busy}, 32'd0);
      send_byte(8'h41);
      check("junk_ferr_kept", {31'd0, frame_error}, 32'd1);
      check("junk_idle", {31'd0, busy}, 32'd0);
      send_byte(8'h52);
      check("cmd_clears_ferr", {31'd0, frame_error}, 32'd0);
      check("cmd_busy", {31'd0, busy}, 32'd1);
      bus_d_in = 8'h5A;
      exp_bus.push_back('{rw:1'b1, addr:16'hD021, data:8'h00});
      exp_tx.push_back(8'h5A);
      send_byte(8'hD0);
      send_byte(8'h21);
      wait_idle(20);

      // Overrun while a write waits for the strobe.
      bus_access_strobe = 1'b0;
      send_byte(8'h57);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h01);
      @(negedge clk);
      rx_data  = 8'hAB;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("ovr_select_on", {31'd0, select}, 32'd1);
      check("ovr_r_w_n", {31'd0, r_w_n}, 32'd0);
      check("ovr_a", {16'd0, a}, 32'h1234);
      check("ovr_d_out", {24'd0, d_out}, 32'hAB);
      @(negedge clk);
      rx_data  = 8'hCC;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("ovr_select_off", {31'd0, select}, 32'd0);
      check("ovr_ferr", {31'd0, frame_error}, 32'd1);
      check("ovr_idle", {31'd0, busy}, 32'd0);
      check("ovr_a_hold", {16'd0, a}, 32'h1234);
      bus_access_strobe = 1'b1;

      // Asynchronous reset in the middle of a write frame.
      send_byte(8'h57);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h03);
      exp_bus.push_back('{rw:1'b0, addr:16'h4000, data:8'h55});
      send_byte(8'h55);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_select", {31'd0, select}, 32'd0);
      check("arst_r_w_n", {31'd0, r_w_n}, 32'd1);
      check("arst_a", {16'd0, a}, 32'd0);
      check("arst_d_out", {24'd0, d_out}, 32'd0);
      check("arst_tx_data", {24'd0, tx_data}, 32'd0);
      check("arst_tx_start", {31'd0, tx_start}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_ferr", {31'd0, frame_error}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      bus_d_in = 8'h3C;
      exp_bus.push_back('{rw:1'b1, addr:16'h0010, data:8'h00});
      exp_tx.push_back(8'h3C);
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h10);
      wait_idle(20);
      repeat (3) @(negedge clk);

      check("bus_queue_drained", exp_bus.size(), 32'd0);
      check("tx_queue_drained", exp_tx.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning the inter-byte timeout in clk cycles (10 ms at 2 MHz).
REQ-002 SHALL have port clk  in  1  system clock (2 MHz, shared with the uart block).
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  in  8  byte received by the uart.
REQ-005 SHALL have port rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-006 SHALL have port tx_busy  in  1  uart transmitter is busy.
REQ-007 SHALL have port tx_data  out  8  reply byte to the uart.
REQ-008 SHALL have port tx_start  out  1  one-cycle pulse that launches tx_data.
REQ-009 SHALL have port bus_access_strobe  in  1  a bus transfer completes on a clk edge where this is 1.
REQ-010 SHALL have port bus_d_in  in  8  read data from the bus.
REQ-011 SHALL have ports a  out  16 (address), d_out  out  8 (write data), select  out  1 (bus request), r_w_n  out  1 (1 = read).
REQ-012 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-013 SHALL have port frame_error  out  1  sticky protocol error flag.

Function
REQ-014 Protocol:
- Write frame: 0x57, addr_hi, addr_lo, len, then N data bytes, where N = len, and len = 0 means N = 256.
- Read frame: 0x52, addr_hi, addr_lo; one reply byte is returned.
REQ-015 States SHALL be IDLE, ADDR_HI, ADDR_LO, LEN, DATA, WRITE, READ, REPLY.
REQ-016 IDLE:
- rx 0x57 or 0x52 -> ADDR_HI, with the command latched and frame_error cleared.
- Any other byte is ignored; the state stays IDLE and frame_error is unchanged.
REQ-017 ADDR_HI -> ADDR_LO -> next state on each rx_valid, latching addr[15:8] and then addr[7:0].
- After ADDR_LO, the next state is LEN for a write and READ for a read.
REQ-018 LEN SHALL load a 9-bit remaining count (0 loads 256), then go to DATA.
REQ-019 DATA, on rx_valid: latch the byte into d_out and go to WRITE.
REQ-020 WRITE:
- Drive select=1, r_w_n=0, a=addr, d_out=byte.
- On an edge with bus_access_strobe=1: addr increments (16-bit wrap, 0xFFFF -> 0x0000) and count decrements.
- Next state is IDLE if count reaches 0, otherwise DATA.
REQ-021 READ:
- Drive select=1, r_w_n=1, a=addr.
- On an edge with bus_access_strobe=1: capture bus_d_in into tx_data and go to REPLY.
REQ-022 REPLY: on the first edge with tx_busy=0, assert tx_start for exactly one cycle, then go to IDLE.
REQ-023 Outside WRITE and READ, select SHALL be 0 and r_w_n SHALL be 1; a and d_out hold their last values.
REQ-024 A byte arriving in WRITE, READ or REPLY is an overrun:
- frame_error is set, the byte is dropped, and the state returns to IDLE.
- A bus cycle in progress is abandoned; select drops on the next cycle.
REQ-025 Timeout:
- A counter runs only in ADDR_HI, ADDR_LO, LEN and DATA, and is cleared on every rx_valid.
- When it reaches TIMEOUT_CYCLES: frame_error is set and the state returns to IDLE.
REQ-026 A new 0x57 or 0x52 frame SHALL be accepted in the cycle immediately after returning to IDLE.

Reset
REQ-027 On reset_n=0, the block SHALL immediately (asynchronously) apply:
- state = IDLE;
- select = 0, r_w_n = 1, a = 0x0000, d_out = 0x00;
- tx_data = 0x00, tx_start = 0;
- busy = 0, frame_error = 0;
- counters = 0.
REQ-028 Reset asserted mid-frame or mid-bus-cycle SHALL abort without any further bus or tx activity; release takes effect on the next clk edge.

Verification
REQ-029 Rx 57 D0 20 01 0E, strobe tied 1 -> one write cycle: a=D020, d_out=0E, r_w_n=0, select high for exactly 1 cycle; then busy=0.
REQ-030 Rx 57 FF FF 02 11 22 -> writes FFFF=11 then 0000=22 (address wrap).
REQ-031 Rx 52 D0 21, bus_d_in=06, strobe delayed 3 cycles, tx_busy=1 for 5 cycles -> select held for 4 cycles; tx_data=06; tx_start pulses once after tx_busy falls.
REQ-032 Rx 57 10 00 00 followed by 256 bytes -> 256 writes covering 1000..10FF; the count=0 case means 256.
REQ-033 Rx 57 D0 then silence for TIMEOUT_CYCLES -> frame_error=1 and IDLE; a subsequent 0x52 clears frame_error; rx 0x41 in IDLE -> no effect.
REQ-034 Rx byte while WRITE is waiting with strobe=0 -> frame_error=1, select drops, IDLE; reset_n pulsed mid-DATA -> all outputs at reset values immediately.
